rbf_accumulator: RTL and testbench

RBF_ACCUMULATOR -- requirements
Module: rbf_accumulator

---
 rtl/rbf_pkg.sv | 15 +
 rtl/sat_add.sv | 20 ++
 rtl/rbf_accumulator.sv | 83 ++++++++
 tb/tb_rbf_accumulator.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rbf_pkg.sv
// rtl/rbf_pkg.sv - shared types and constants for the RBF decision accumulator
package rbf_pkg;

    // Width of one weighted kernel term arriving from the exp lookup stage
    localparam int TERM_W          = 10;
    localparam int DEFAULT_N_TERMS = 64;
    localparam int DEFAULT_SUM_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - saturating add of a 10-bit unsigned term into a SUM_W-bit sum
module sat_add
    import rbf_pkg::*;
#(
    parameter int SUM_W = DEFAULT_SUM_W
) (
    input  logic [SUM_W-1:0]  acc,
    input  logic [TERM_W-1:0] term,
    output logic [SUM_W-1:0]  sum
);

    logic [SUM_W:0] wide;

    // One extra bit catches the carry; any carry clamps to all ones
    always_comb begin
        wide = {1'b0, acc} + {{(SUM_W + 1 - TERM_W){1'b0}}, term};
        sum  = wide[SUM_W] ? {SUM_W{1'b1}} : wide[SUM_W-1:0];
    end

endmodule

// File: rtl/rbf_accumulator.sv
// rtl/rbf_accumulator.sv - sums N_TERMS kernel terms and compares against a threshold
module rbf_accumulator
    import rbf_pkg::*;
#(
    parameter int N_TERMS = DEFAULT_N_TERMS,
    parameter int SUM_W   = DEFAULT_SUM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SUM_W-1:0]  thresh,
    input  logic              in_valid,
    input  logic [TERM_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic [SUM_W-1:0]  sum_out,
    output logic              sum_valid,
    output logic              class_hit
);

    localparam int              CNT_W     = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TERMS - 1);

    state_t             state;
    logic [SUM_W-1:0]   acc;
    logic [SUM_W-1:0]   acc_next;
    logic [SUM_W-1:0]   thr;
    logic [CNT_W-1:0]   cnt;

    // Ready depends on state alone so upstream never sees a valid->ready loop
    assign in_ready = (state == ACC);
    assign busy     = (state != IDLE);

    sat_add #(.SUM_W(SUM_W)) u_sat_add (
        .acc  (acc),
        .term (in_data),
        .sum  (acc_next)
    );

    // Control FSM with accumulator, term counter and registered result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            thr       <= '0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
            class_hit <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        cnt   <= '0;
                        thr   <= thresh;
                        state <= ACC;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc <= acc_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_IDX) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    sum_out   <= acc;
                    class_hit <= (acc >= thr);
                    sum_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rbf_accumulator.sv
// tb/tb_rbf_accumulator.sv - directed self-checking bench for rbf_accumulator
module tb_rbf_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N_TERMS=4, SUM_W=16
    logic        start_a = 0, in_valid_a = 0, in_ready_a, busy_a, sum_valid_a, class_hit_a;
    logic [15:0] thresh_a = 0, sum_out_a;
    logic [9:0]  in_data_a = 0;
    // Instance B: N_TERMS=8, SUM_W=12
    logic        start_b = 0, in_valid_b = 0, in_ready_b, busy_b, sum_valid_b, class_hit_b;
    logic [11:0] thresh_b = 0, sum_out_b;
    logic [9:0]  in_data_b = 0;
    // Instance C: N_TERMS=1, SUM_W=16
    logic        start_c = 0, in_valid_c = 0, in_ready_c, busy_c, sum_valid_c, class_hit_c;
    logic [15:0] thresh_c = 0, sum_out_c;
    logic [9:0]  in_data_c = 0;

    rbf_accumulator #(.N_TERMS(4), .SUM_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .thresh(thresh_a),
        .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
        .busy(busy_a), .sum_out(sum_out_a), .sum_valid(sum_valid_a), .class_hit(class_hit_a));

    rbf_accumulator #(.N_TERMS(8), .SUM_W(12)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .thresh(thresh_b),
        .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
        .busy(busy_b), .sum_out(sum_out_b), .sum_valid(sum_valid_b), .class_hit(class_hit_b));

    rbf_accumulator #(.N_TERMS(1), .SUM_W(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .thresh(thresh_c),
        .in_valid(in_valid_c), .in_data(in_data_c), .in_ready(in_ready_c),
        .busy(busy_c), .sum_out(sum_out_c), .sum_valid(sum_valid_c), .class_hit(class_hit_c));

    int n_cmp = 0;
    int n_mis = 0;
    int pulses_a = 0;
    int pulses_b = 0;
    int pulses_c = 0;

    // Count sum_valid pulses on every edge for the exactly-one checks
    always @(posedge clk) begin
        if (sum_valid_a) pulses_a <= pulses_a + 1;
        if (sum_valid_b) pulses_b <= pulses_b + 1;
        if (sum_valid_c) pulses_c <= pulses_c + 1;
    end

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_run_a(input logic [15:0] t);
        start_a  = 1'b1;
        thresh_a = t;
        @(negedge clk);
        start_a  = 1'b0;
        thresh_a = 16'hFFFF;
    endtask

    // Wait 'gap' idle cycles with junk on in_data, then present one term for one cycle
    task automatic term_a(input logic [9:0] d, input int gap);
        for (int i = 0; i < gap; i++) begin
            in_valid_a = 1'b0;
            in_data_a  = 10'h3FF;
            @(negedge clk);
        end
        in_valid_a = 1'b1;
        in_data_a  = d;
        @(negedge clk);
        in_valid_a = 1'b0;
        in_data_a  = 10'h000;
    endtask

    initial begin
        int p0;

        // Reset state
        @(negedge clk);
        chk("rst_sum_out", sum_out_a, 0);
        chk("rst_sum_valid", sum_valid_a, 0);
        chk("rst_class_hit", class_hit_a, 0);
        chk("rst_in_ready", in_ready_a, 0);
        chk("rst_busy", busy_a, 0);

        // Release reset together with start: first edge must honour it
        rst_n = 1'b1;
        start_run_a(16'd17);
        chk("r1_busy_acc", busy_a, 1);
        chk("r1_ready_acc", in_ready_a, 1);
        term_a(10'd2, 0);
        term_a(10'd3, 0);
        term_a(10'd5, 0);
        term_a(10'd7, 0);
        chk("r1_done_busy", busy_a, 1);
        chk("r1_done_ready", in_ready_a, 0);
        chk("r1_done_nopulse", sum_valid_a, 0);
        @(negedge clk);
        chk("r1_pulse", sum_valid_a, 1);
        chk("r1_sum", sum_out_a, 17);
        chk("r1_hit", class_hit_a, 1);
        @(negedge clk);
        chk("r1_pulse_end", sum_valid_a, 0);
        chk("r1_idle_busy", busy_a, 0);
        chk("r1_hold_sum", sum_out_a, 17);
        chk("r1_pulses", pulses_a, 1);

        // Stalled run with gaps and junk data while in_valid is low
        start_run_a(16'd18);
        term_a(10'd2, 3);
        term_a(10'd3, 3);
        term_a(10'd5, 3);
        term_a(10'd7, 3);
        @(negedge clk);
        chk("r2_pulse", sum_valid_a, 1);
        chk("r2_sum", sum_out_a, 17);
        chk("r2_hit", class_hit_a, 0);
        @(negedge clk);
        chk("r2_pulses", pulses_a, 2);

        // Start pulses during ACC and DONE must not relatch or restart
        start_run_a(16'd100);
        term_a(10'd2, 0);
        start_a  = 1'b1;
        thresh_a = 16'd0;
        @(negedge clk);
        start_a  = 1'b0;
        term_a(10'd3, 0);
        term_a(10'd5, 0);
        term_a(10'd7, 0);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("r3_pulse", sum_valid_a, 1);
        chk("r3_sum", sum_out_a, 17);
        chk("r3_hit", class_hit_a, 0);
        chk("r3_no_restart", busy_a, 0);
        repeat (6) @(negedge clk);
        chk("r3_pulses", pulses_a, 3);
        chk("r3_still_idle", busy_a, 0);

        // Reset in the middle of a run, then a clean run of four ones
        start_run_a(16'd4);
        term_a(10'd9, 0);
        term_a(10'd9, 0);
        rst_n = 1'b0;
        #1;
        chk("r4_async_busy", busy_a, 0);
        chk("r4_async_ready", in_ready_a, 0);
        chk("r4_async_sum", sum_out_a, 0);
        chk("r4_async_hit", class_hit_a, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        p0 = pulses_a;
        start_run_a(16'd4);
        term_a(10'd1, 0);
        term_a(10'd1, 0);
        term_a(10'd1, 0);
        term_a(10'd1, 0);
        @(negedge clk);
        chk("r4_pulse", sum_valid_a, 1);
        chk("r4_sum", sum_out_a, 4);
        chk("r4_hit", class_hit_a, 1);
        @(negedge clk);
        chk("r4_pulses", pulses_a - p0, 1);

        // Saturation with SUM_W=12: 8*1023 clamps at 4095
        start_b  = 1'b1;
        thresh_b = 12'd4095;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid_b = 1'b1;
            in_data_b  = 10'd1023;
            @(negedge clk);
        end
        in_valid_b = 1'b0;
        @(negedge clk);
        chk("sat_pulse", sum_valid_b, 1);
        chk("sat_sum", sum_out_b, 4095);
        chk("sat_hit", class_hit_b, 1);
        @(negedge clk);
        chk("sat_pulses", pulses_b, 1);

        // Single-term run, zero term against zero threshold
        start_c  = 1'b1;
        thresh_c = 16'd0;
        @(negedge clk);
        start_c    = 1'b0;
        in_valid_c = 1'b1;
        in_data_c  = 10'd0;
        @(negedge clk);
        in_valid_c = 1'b0;
        chk("n1_done_busy", busy_c, 1);
        @(negedge clk);
        chk("n1_pulse", sum_valid_c, 1);
        chk("n1_sum", sum_out_c, 0);
        chk("n1_hit", class_hit_c, 1);
        @(negedge clk);
        chk("n1_busy_after", busy_c, 0);
        chk("n1_pulses", pulses_c, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
